// File: rtl/rv32_bus_arbiter.sv
// Shares one memory port between the fetch bus and the data bus.
// Data has priority; a streak counter forces a fetch after long data runs.
module rv32_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic [31:0] mem_address_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [3:0]  mem_write_mask_out,
    output logic [31:0] mem_write_value_out,
    input  logic [31:0] mem_read_value_in,
    input  logic        mem_ready_in,
    output logic [1:0]  owner_out
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        OWN_INSTR,
        OWN_DATA
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

    state_t        state, state_nxt;
    owner_t        owner;
    logic [SW-1:0] streak, streak_nxt;
    logic          instr_req, data_req, starved, owner_req;

    assign instr_req = instr_read_in;
    assign data_req  = data_read_in | data_write_in;
    assign starved   = instr_req && (streak == LIMIT);

    // IDLE picks the owner in the same cycle; OWN_x keeps it locked.
    always_comb begin
        owner = OWN_NONE;
        case (state)
            IDLE: begin
                if (data_req && !starved) owner = OWN_D;
                else if (instr_req)       owner = OWN_I;
            end
            OWN_INSTR: owner = OWN_I;
            OWN_DATA:  owner = OWN_D;
            default:   owner = OWN_NONE;
        endcase
        if (!reset_) owner = OWN_NONE;
    end

    always_comb begin
        mem_address_out     = '0;
        mem_read_out        = 1'b0;
        mem_write_out       = 1'b0;
        mem_write_mask_out  = '0;
        mem_write_value_out = '0;
        instr_ready_out     = 1'b0;
        data_ready_out      = 1'b0;
        owner_req           = 1'b0;
        case (owner)
            OWN_I: begin
                mem_address_out = instr_address_in;
                mem_read_out    = instr_read_in;
                instr_ready_out = mem_ready_in & instr_req;
                owner_req       = instr_req;
            end
            OWN_D: begin
                mem_address_out     = data_address_in;
                mem_read_out        = data_read_in;
                mem_write_out       = data_write_in;
                mem_write_mask_out  = data_write_mask_in;
                mem_write_value_out = data_write_value_in;
                data_ready_out      = mem_ready_in & data_req;
                owner_req           = data_req;
            end
            default: ;
        endcase
    end

    assign instr_read_value_out = mem_read_value_in;
    assign data_read_value_out  = mem_read_value_in;
    assign owner_out            = owner;

    // Completion or withdrawal both return to IDLE.
    always_comb begin
        state_nxt = IDLE;
        if (owner_req && !mem_ready_in) begin
            state_nxt = (owner == OWN_I) ? OWN_INSTR : OWN_DATA;
        end
    end

    always_comb begin
        streak_nxt = streak;
        if (!instr_req || instr_ready_out) begin
            streak_nxt = '0;
        end else if (data_ready_out && streak != LIMIT) begin
            streak_nxt = streak + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Randomized bench for rv32_bus_arbiter against a transfer-level model.
// Directed sequences cover fetch, contention, starvation, store, withdraw.
module tb_rv32_bus_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset_;
    logic [31:0] instr_address_in;
    logic        instr_read_in;
    logic [31:0] instr_read_value_out;
    logic        instr_ready_out;
    logic [31:0] data_address_in;
    logic        data_read_in;
    logic        data_write_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic [31:0] data_read_value_out;
    logic        data_ready_out;
    logic [31:0] mem_address_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [3:0]  mem_write_mask_out;
    logic [31:0] mem_write_value_out;
    logic [31:0] mem_read_value_in;
    logic        mem_ready_in;
    logic [1:0]  owner_out;

    rv32_bus_arbiter #(.STARVE_LIMIT(L)) dut (
        .clk                  (clk),
        .reset_               (reset_),
        .instr_address_in     (instr_address_in),
        .instr_read_in        (instr_read_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_ready_out      (instr_ready_out),
        .data_address_in      (data_address_in),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_write_value_in  (data_write_value_in),
        .data_read_value_out  (data_read_value_out),
        .data_ready_out       (data_ready_out),
        .mem_address_out      (mem_address_out),
        .mem_read_out         (mem_read_out),
        .mem_write_out        (mem_write_out),
        .mem_write_mask_out   (mem_write_mask_out),
        .mem_write_value_out  (mem_write_value_out),
        .mem_read_value_in    (mem_read_value_in),
        .mem_ready_in         (mem_ready_in),
        .owner_out            (owner_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: who holds the bus across cycles, and data wins since last fetch.
    int m_holder = 0;
    int m_wins   = 0;
    int seen_ir, seen_dr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        int   who;
        logic ireq, dreq, ir, dr, wreq;
        @(negedge clk);
        ireq = instr_read_in;
        dreq = data_read_in | data_write_in;
        if (!reset_) who = 0;
        else if (m_holder != 0) who = m_holder;
        else if (dreq && !(ireq && m_wins == L)) who = 2;
        else if (ireq) who = 1;
        else who = 0;
        ir = mem_ready_in && who == 1 && ireq;
        dr = mem_ready_in && who == 2 && dreq;
        check("owner", {30'd0, owner_out}, who);
        check("iready", {31'd0, instr_ready_out}, {31'd0, ir});
        check("dready", {31'd0, data_ready_out}, {31'd0, dr});
        check("ival", instr_read_value_out, mem_read_value_in);
        check("dval", data_read_value_out, mem_read_value_in);
        if (who == 0) begin
            check("addr0", mem_address_out, 0);
            check("rd0", {31'd0, mem_read_out}, 0);
            check("wr0", {31'd0, mem_write_out}, 0);
            check("mask0", {28'd0, mem_write_mask_out}, 0);
            check("wval0", mem_write_value_out, 0);
        end else if (who == 1) begin
            check("addr_i", mem_address_out, instr_address_in);
            check("rd_i", {31'd0, mem_read_out}, {31'd0, instr_read_in});
            check("wr_i", {31'd0, mem_write_out}, 0);
            check("mask_i", {28'd0, mem_write_mask_out}, 0);
        end else begin
            check("addr_d", mem_address_out, data_address_in);
            check("rd_d", {31'd0, mem_read_out}, {31'd0, data_read_in});
            check("wr_d", {31'd0, mem_write_out}, {31'd0, data_write_in});
            check("mask_d", {28'd0, mem_write_mask_out},
                  {28'd0, data_write_mask_in});
            check("wval_d", mem_write_value_out, data_write_value_in);
        end
        seen_ir = int'(instr_ready_out);
        seen_dr = int'(data_ready_out);
        wreq = (who == 1) ? ireq : (who == 2) ? dreq : 1'b0;
        if (!reset_) begin
            m_holder = 0;
            m_wins   = 0;
        end else begin
            m_holder = (wreq && !mem_ready_in) ? who : 0;
            if (!ireq || ir) m_wins = 0;
            else if (dr && m_wins < L) m_wins = m_wins + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        instr_read_in       = 0;
        data_read_in        = 0;
        data_write_in       = 0;
        data_write_mask_in  = 0;
        data_write_value_in = 0;
        mem_ready_in        = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset_ = 0;
        cycle();
        cycle();
        reset_ = 1;
    endtask

    int ni, nd;

    initial begin
        instr_address_in  = 32'h100;
        data_address_in   = 32'h2000;
        mem_read_value_in = 32'h1234_5678;
        do_reset();
        cycle();

        instr_read_in = 1;
        mem_ready_in  = 1;
        repeat (3) cycle();
        check("fetch0_ready", seen_ir, 1);

        quiet();
        instr_read_in = 1;
        data_read_in  = 1;
        cycle();
        cycle();
        mem_ready_in = 1;
        cycle();
        check("contend_dready", seen_dr, 1);
        data_read_in = 0;
        cycle();
        check("contend_fetch", seen_ir, 1);

        do_reset();
        instr_read_in = 1;
        data_read_in  = 1;
        mem_ready_in  = 1;
        ni = 0;
        nd = 0;
        repeat (5) begin
            cycle();
            ni += seen_ir;
            nd += seen_dr;
        end
        check("starve_data", nd, 4);
        check("starve_instr", ni, 1);
        cycle();
        check("starve_resume", seen_dr, 1);

        quiet();
        data_write_in       = 1;
        data_write_mask_in  = 4'b0011;
        data_write_value_in = 32'hDEAD_BEEF;
        data_address_in     = 32'h40;
        mem_ready_in        = 1;
        cycle();

        quiet();
        instr_read_in = 1;
        cycle();
        instr_read_in = 0;
        data_read_in  = 1;
        mem_ready_in  = 1;
        cycle();
        check("withdraw_noready", seen_ir, 0);
        cycle();

        quiet();
        data_read_in = 1;
        cycle();
        reset_ = 0;
        cycle();
        reset_ = 1;
        quiet();
        cycle();

        for (int i = 0; i < 3000; i++) begin
            reset_ = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 9) == 0) instr_read_in = ~instr_read_in;
            if ($urandom_range(0, 9) == 0) data_read_in = ~data_read_in;
            if ($urandom_range(0, 19) == 0) data_write_in = ~data_write_in;
            mem_ready_in        = ($urandom_range(0, 9) < 6);
            instr_address_in    = $urandom;
            data_address_in     = $urandom;
            data_write_mask_in  = 4'($urandom);
            data_write_value_in = $urandom;
            mem_read_value_in   = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
